// File: rtl/branch_cond_unit.sv
// Branch condition unit: captures ALU compare flags, evaluates a branch
// condition against them and holds the resolved next PC in a one-entry
// output register with valid/ready handshake. Counts taken branches delivered.
// Optional build macro: BRCOND_FWD_EN -- a compare result arriving in the same
// cycle as a branch is forwarded into the evaluation instead of blocking it.
module branch_cond_unit #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flag_we,
    input  logic          eq,
    input  logic          lt,
    input  logic          gt,
    input  logic          flush,
    input  logic          br_valid,
    output logic          br_ready,
    input  logic [2:0]    br_cond,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] br_fallthru,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_taken,
    output logic [AW-1:0] res_pc,
    output logic [2:0]    flags_q,
    output logic          flags_vld,
    output logic [7:0]    taken_cnt
);

    localparam int unsigned CW = 8;

    localparam logic [2:0] C_EQ     = 3'b000;
    localparam logic [2:0] C_NE     = 3'b001;
    localparam logic [2:0] C_LT     = 3'b010;
    localparam logic [2:0] C_LE     = 3'b011;
    localparam logic [2:0] C_GT     = 3'b100;
    localparam logic [2:0] C_GE     = 3'b101;
    localparam logic [2:0] C_ALWAYS = 3'b110;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e     state_q;
    logic [2:0] eval_flags_c;
    logic       cond_true_c;
    logic       stall_c;
    logic       accept_c;
    logic       drain_c;

    assign res_valid = (state_q == FULL);

    // Select flags for evaluation, resolve the condition, derive handshake.
    always_comb begin
        eval_flags_c = flags_q;
`ifdef BRCOND_FWD_EN
        if (flag_we) begin
            eval_flags_c = {eq, lt, gt};
        end
`endif
        case (br_cond)
            C_EQ:     cond_true_c = eval_flags_c[2];
            C_NE:     cond_true_c = !eval_flags_c[2];
            C_LT:     cond_true_c = eval_flags_c[1];
            C_LE:     cond_true_c = eval_flags_c[1] | eval_flags_c[2];
            C_GT:     cond_true_c = eval_flags_c[0];
            C_GE:     cond_true_c = eval_flags_c[0] | eval_flags_c[2];
            C_ALWAYS: cond_true_c = 1'b1;
            default:  cond_true_c = 1'b0;
        endcase

        // Flag-dependent conditions wait until some compare has been seen.
        stall_c  = (br_cond <= C_GE) && !flags_vld && !flag_we;
        br_ready = (!res_valid || res_ready) && !flush && !stall_c;
`ifdef BRCOND_FWD_EN
`else
        // Without forwarding, a branch must see the flags after they settle.
        if (flag_we) begin
            br_ready = 1'b0;
        end
`endif
        accept_c = br_valid && br_ready;
        drain_c  = res_valid && res_ready;
    end

    // Flag register, output-stage FSM, result payload and taken counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            res_taken <= 1'b0;
            res_pc    <= '0;
            flags_q   <= 3'b000;
            flags_vld <= 1'b0;
            taken_cnt <= '0;
        end else begin
            if (flag_we) begin
                flags_q   <= {eq, lt, gt};
                flags_vld <= 1'b1;
            end

            case (state_q)
                EMPTY: begin
                    if (!flush && accept_c) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (flush) begin
                        state_q <= EMPTY;
                    end else if (drain_c && !accept_c) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase

            if (!flush && accept_c) begin
                res_taken <= cond_true_c;
                res_pc    <= cond_true_c ? br_target : br_fallthru;
            end

            if (drain_c && res_taken && !flush) begin
                taken_cnt <= taken_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: reset, condition evaluation, stall,
// backpressure, flush, counter wrap and asynchronous reset mid-stream.
module tb_branch_cond_unit;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst_n;
    logic          flag_we;
    logic          eq;
    logic          lt;
    logic          gt;
    logic          flush;
    logic          br_valid;
    logic          br_ready;
    logic [2:0]    br_cond;
    logic [AW-1:0] br_target;
    logic [AW-1:0] br_fallthru;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic [AW-1:0] res_pc;
    logic [2:0]    flags_q;
    logic          flags_vld;
    logic [7:0]    taken_cnt;

    int total = 0;
    int bad   = 0;

    branch_cond_unit #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt),
        .flush      (flush),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .br_fallthru(br_fallthru),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_taken  (res_taken),
        .res_pc     (res_pc),
        .flags_q    (flags_q),
        .flags_vld  (flags_vld),
        .taken_cnt  (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are settled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_taken"}, 32'(res_taken), 32'd0);
        chk({tag, "_res_pc"},    32'(res_pc),    32'd0);
        chk({tag, "_flags_q"},   32'(flags_q),   32'd0);
        chk({tag, "_flags_vld"}, 32'(flags_vld), 32'd0);
        chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flag_we = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
        flush = 1'b0; br_valid = 1'b0; br_cond = 3'b111;
        br_target = '0; br_fallthru = '0; res_ready = 1'b0;
        #2;
        check_reset_outputs("rst");
        #10 rst_n = 1'b1;
        tick();

        // Flag-dependent condition with no compare ever seen stalls.
        br_valid = 1'b1; br_cond = 3'b000; br_target = 8'h40; br_fallthru = 8'h11;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_br_ready", 32'(br_ready), 32'd0);
            tick();
            chk("stall_res_valid", 32'(res_valid), 32'd0);
        end

        // ALWAYS never stalls and resolves taken the next edge.
        br_cond = 3'b110;
        #1;
        chk("always_br_ready", 32'(br_ready), 32'd1);
        tick();
        chk("always_valid", 32'(res_valid), 32'd1);
        chk("always_taken", 32'(res_taken), 32'd1);
        chk("always_pc",    32'(res_pc),    32'h40);
        br_valid = 1'b0; res_ready = 1'b1;
        tick();
        chk("always_drained", 32'(res_valid), 32'd0);
        chk("cnt_1",          32'(taken_cnt), 32'd1);

        // Capture eq=1, then LE taken and GT not taken.
        res_ready = 1'b0; flag_we = 1'b1; eq = 1'b1; lt = 1'b0; gt = 1'b0;
        tick();
        flag_we = 1'b0; eq = 1'b0;
        chk("flags_eq",  32'(flags_q),   32'b100);
        chk("flags_vld", 32'(flags_vld), 32'd1);
        br_valid = 1'b1; br_cond = 3'b011; br_target = 8'h20; br_fallthru = 8'h05;
        tick();
        chk("le_taken", 32'(res_taken), 32'd1);
        chk("le_pc",    32'(res_pc),    32'h20);
        res_ready = 1'b1; br_cond = 3'b100;
        #1;
        chk("gt_br_ready", 32'(br_ready), 32'd1);
        tick();
        chk("gt_valid", 32'(res_valid), 32'd1);
        chk("gt_taken", 32'(res_taken), 32'd0);
        chk("gt_pc",    32'(res_pc),    32'h05);
        chk("cnt_2",    32'(taken_cnt), 32'd2);
        br_valid = 1'b0;
        tick();
        chk("gt_drained", 32'(res_valid), 32'd0);
        chk("cnt_2_hold", 32'(taken_cnt), 32'd2);

        // Compare and LT branch offered in the same cycle.
        res_ready = 1'b0;
        flag_we = 1'b1; lt = 1'b1;
        br_valid = 1'b1; br_cond = 3'b010; br_target = 8'h30; br_fallthru = 8'h31;
        #1;
`ifdef BRCOND_FWD_EN
        chk("fwd_br_ready", 32'(br_ready), 32'd1);
        tick();
        flag_we = 1'b0; lt = 1'b0; br_valid = 1'b0;
`else
        chk("nofwd_br_ready", 32'(br_ready), 32'd0);
        tick();
        chk("nofwd_not_acc", 32'(res_valid), 32'd0);
        flag_we = 1'b0; lt = 1'b0;
        #1;
        chk("nofwd_br_ready2", 32'(br_ready), 32'd1);
        tick();
        br_valid = 1'b0;
`endif
        chk("lt_valid", 32'(res_valid), 32'd1);
        chk("lt_taken", 32'(res_taken), 32'd1);
        chk("lt_pc",    32'(res_pc),    32'h30);
        chk("flags_lt", 32'(flags_q),   32'b010);
        res_ready = 1'b1;
        tick();
        chk("cnt_3", 32'(taken_cnt), 32'd3);

        // Backpressure: result held stable, then back-to-back streaming.
        res_ready = 1'b0; br_valid = 1'b1; br_cond = 3'b110; br_target = 8'h50;
        tick();
        br_target = 8'h51;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_br_ready", 32'(br_ready), 32'd0);
            tick();
            chk("bp_pc_stable", 32'(res_pc), 32'h50);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_valid", 32'(res_valid), 32'd1);
            chk("b2b_pc",    32'(res_pc),    32'(8'h51 + i));
            chk("b2b_cnt",   32'(taken_cnt), 32'(4 + i));
            br_target = br_target + 8'h01;
        end
        br_valid = 1'b0;
        tick();
        chk("b2b_drained", 32'(res_valid), 32'd0);
        chk("cnt_7",       32'(taken_cnt), 32'd7);

        // Flush while FULL drops the result, blocks the branch, still loads flags.
        res_ready = 1'b0; br_valid = 1'b1; br_target = 8'h60;
        tick();
        chk("pre_flush_valid", 32'(res_valid), 32'd1);
        flush = 1'b1; res_ready = 1'b1; flag_we = 1'b1; gt = 1'b1; br_target = 8'h61;
        #1;
        chk("flush_br_ready", 32'(br_ready), 32'd0);
        tick();
        flush = 1'b0; flag_we = 1'b0; gt = 1'b0; br_valid = 1'b0;
        chk("flush_valid", 32'(res_valid), 32'd0);
        chk("flush_cnt",   32'(taken_cnt), 32'd7);
        chk("flush_flags", 32'(flags_q),   32'b001);

        // Asynchronous reset while a result is pending.
        res_ready = 1'b0; br_valid = 1'b1; br_target = 8'h70;
        tick();
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        res_ready = 1'b1; br_valid = 1'b1; br_cond = 3'b110; br_target = 8'h7f;
        #1 rst_n = 1'b1;

        // 256 taken deliveries wrap the counter back to zero.
        tick();
        chk("post_rst_accept", 32'(res_valid), 32'd1);
        chk("post_rst_cnt",    32'(taken_cnt), 32'd0);
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        chk("cnt_255", 32'(taken_cnt), 32'd255);
        br_valid = 1'b0;
        tick();
        chk("cnt_wrap",   32'(taken_cnt), 32'd0);
        chk("wrap_empty", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
